// File: rtl/key_debounce_pkg.sv
// Shared constants and width helpers for the push-button debouncer.
package key_pkg;

    localparam logic KEY_PRESSED = 1'b0;

    localparam int DB_10MS_50MHZ       = 500000;
    localparam int REPEAT_DELAY_500MS  = 25000000;
    localparam int REPEAT_PERIOD_100MS = 5000000;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key pin / debounced event bundle between the board pins and the consumers.
interface key_debounce_if #(
    parameter int NKEYS = 4
);
    logic [NKEYS-1:0] key_n_i;
    logic [NKEYS-1:0] key_level_o;
    logic [NKEYS-1:0] press_o;
    logic [NKEYS-1:0] release_o;

    modport master (output key_n_i, input key_level_o, input press_o, input release_o);
    modport slave  (input key_n_i, output key_level_o, output press_o, output release_o);
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce qualifier, press/release pulses.
// Auto-repeat of press pulses while held is built only when KEY_REPEAT_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DB_CYCLES     = DB_10MS_50MHZ,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_100MS
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int              DB_W    = cnt_w(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            w_pressed;
    logic            w_flip;
    logic            w_rpt_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = (r_sync2 == KEY_PRESSED);
    assign w_flip    = (w_pressed != r_level) && (r_db_cnt == DB_LAST);

    // Any sample agreeing with the current level restarts qualification.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= (w_flip & w_pressed) | w_rpt_hit;
            r_release <= w_flip & ~w_pressed;
            if (w_pressed == r_level) begin
                r_db_cnt <= '0;
            end else if (w_flip) begin
                r_db_cnt <= '0;
                r_level  <= w_pressed;
            end else begin
                r_db_cnt <= r_db_cnt + DB_ONE;
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int                HOLD_W = cnt_w(max_i(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [HOLD_W-1:0] H_DLY  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] H_PER  = HOLD_W'(REPEAT_PERIOD);
    localparam logic [HOLD_W-1:0] H_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_rpt_phase;
    logic [HOLD_W-1:0] w_hold_thr;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; counter restarts at each pulse.
    assign w_hold_thr = r_rpt_phase ? H_PER : H_DLY;
    assign w_rpt_hit  = r_level && !w_flip && ((r_hold_cnt + H_ONE) == w_hold_thr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hold_cnt  <= '0;
            r_rpt_phase <= 1'b0;
        end else if (!r_level || w_flip) begin
            r_hold_cnt  <= '0;
            r_rpt_phase <= 1'b0;
        end else if (w_rpt_hit) begin
            r_hold_cnt  <= '0;
            r_rpt_phase <= 1'b1;
        end else begin
            r_hold_cnt  <= r_hold_cnt + H_ONE;
        end
    end
`else
    logic w_unused_rpt;
    assign w_unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign w_rpt_hit    = 1'b0;
`endif

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// NKEYS independent debounced key channels behind the raw active-low key pins.
// Define KEY_REPEAT_EN to enable auto-repeat press pulses while a key is held.
module key_debounce
    import key_pkg::*;
#(
    parameter int NKEYS         = 4,
    parameter int DB_CYCLES     = DB_10MS_50MHZ,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_100MS
) (
    input  logic           clk,
    input  logic           rstn,
    key_debounce_if.slave  bus
);

    logic [NKEYS-1:0] w_level;
    logic [NKEYS-1:0] w_press;
    logic [NKEYS-1:0] w_release;

    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_ch
        key_debounce_ch #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .rstn     (rstn),
            .i_key_n  (bus.key_n_i[gi]),
            .o_level  (w_level[gi]),
            .o_press  (w_press[gi]),
            .o_release(w_release[gi])
        );
    end

    assign bus.key_level_o = w_level;
    assign bus.press_o     = w_press;
    assign bus.release_o   = w_release;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_key_debounce;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   e;

    key_debounce_if #(.NKEYS(4)) bus ();

    key_debounce #(
        .NKEYS        (4),
        .DB_CYCLES    (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic chk_all(input string tag, input int ed,
                           input logic [3:0] lv, input logic [3:0] pr, input logic [3:0] rl);
        chk($sformatf("%s_lvl_e%0d", tag, ed), bus.key_level_o, lv);
        chk($sformatf("%s_prs_e%0d", tag, ed), bus.press_o,     pr);
        chk($sformatf("%s_rel_e%0d", tag, ed), bus.release_o,   rl);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clean reset with all keys released; returns just after "edge 0".
    task automatic do_reset();
        bus.key_n_i = 4'hF;
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        bus.key_n_i = 4'h0;

        // Reset with all keys held down
        repeat (3) step();
        chk_all("rst_hold", 0, 4'h0, 4'h0, 4'h0);
        rstn = 1'b1;
        for (e = 1; e <= 8; e++) begin
            step();
            chk_all("rst_rel", e, (e >= 6) ? 4'hF : 4'h0, (e == 6) ? 4'hF : 4'h0, 4'h0);
        end

        // Single press and release on key 2
        do_reset();
        bus.key_n_i[2] = 1'b0;
        for (e = 1; e <= 30; e++) begin
            step();
            chk_all("single", e, (e >= 6 && e < 26) ? 4'h4 : 4'h0,
                    (e == 6) ? 4'h4 : 4'h0, (e == 26) ? 4'h4 : 4'h0);
            if (e == 20) bus.key_n_i[2] = 1'b1;
        end

        // Bounce: low 3 / high 1 five times, then stable low from edge 20
        do_reset();
        bus.key_n_i[0] = 1'b0;
        for (e = 1; e <= 32; e++) begin
            step();
            chk_all("bounce", e, (e >= 26) ? 4'h1 : 4'h0, (e == 26) ? 4'h1 : 4'h0, 4'h0);
            if (e < 20 && (e % 4) == 3) bus.key_n_i[0] = 1'b1;
            if (e <= 20 && (e % 4) == 0) bus.key_n_i[0] = 1'b0;
        end

        // Independence: key0 at edge 0, key3 at edge 2
        do_reset();
        bus.key_n_i[0] = 1'b0;
        for (e = 1; e <= 10; e++) begin
            step();
            chk_all("indep", e, {(e >= 8), 2'b00, (e >= 6)},
                    {(e == 8), 2'b00, (e == 6)}, 4'h0);
            if (e == 2) bus.key_n_i[3] = 1'b0;
        end

        // Reset in the middle of qualification
        do_reset();
        bus.key_n_i[1] = 1'b0;
        for (e = 1; e <= 15; e++) begin
            step();
            chk_all("midrst", e, (e >= 12) ? 4'h2 : 4'h0, (e == 12) ? 4'h2 : 4'h0, 4'h0);
            if (e == 4) rstn = 1'b0;
            if (e == 6) rstn = 1'b1;
        end

        // Long hold on key 1, released at edge 24 (debounced release at edge 30)
        do_reset();
        bus.key_n_i[1] = 1'b0;
        for (e = 1; e <= 45; e++) begin
            logic exp_p;
            step();
`ifdef KEY_REPEAT_EN
            exp_p = (e == 6) || (e == 16) || (e == 21) || (e == 26);
`else
            exp_p = (e == 6);
`endif
            chk_all("hold", e, (e >= 6 && e < 30) ? 4'h2 : 4'h0,
                    {2'b00, exp_p, 1'b0}, (e == 30) ? 4'h2 : 4'h0);
            if (e == 24) bus.key_n_i[1] = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
